// File: rtl/sd_cmd_response_receiver_pkg.sv
// Shared SD CMD-line definitions: CRC7, response lengths,
// Ncr timeout and receiver state encoding.
package sd_cmd_response_receiver_pkg;

  localparam logic [6:0] CRC7_POLY = 7'h09;
  localparam int RESP_SHORT = 48;
  localparam int RESP_LONG = 136;
  localparam int NCR_TIMEOUT = 64;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_START,
    RECEIVE,
    DONE
  } sd_state_e;

  function automatic logic [6:0] crc7_next(
    input logic [6:0] c,
    input logic b
  );
    logic fb;
    fb = c[6] ^ b;
    return {c[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_cmd_response_receiver_crc7.sv
// Serial CRC7 (x^7+x^3+1), MSB-first, with clear and enable.
// Shared by the command serializer and the response receiver.
import sd_cmd_response_receiver_pkg::*;

module sd_crc7 (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       din,
  output logic [6:0] crc
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      crc <= '0;
    end else if (clear) begin
      crc <= '0;
    end else if (enable) begin
      crc <= crc7_next(crc, din);
    end
  end

endmodule

// File: rtl/sd_cmd_response_receiver.sv
// SD CMD-line response receiver: waits for a start bit, shifts in a
// 48/136-bit response and checks transmission bit, CRC7 and end bit.
import sd_cmd_response_receiver_pkg::*;

module sd_cmd_response_receiver #(
  parameter int BITS            = RESP_SHORT,
  parameter int BITS_LONG       = RESP_LONG,
  parameter int BITS_COUNTER    = 8,
  parameter int TIMEOUT         = NCR_TIMEOUT,
  parameter int TIMEOUT_COUNTER = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 long_resp,
  input  logic                 check_crc,
  input  logic                 in,
  output logic [BITS_LONG-1:0] out,
  output logic                 done,
  output logic                 crc_err,
  output logic                 frame_err,
  output logic                 timeout
);

  localparam logic [BITS_COUNTER-1:0] LAST_S =
    BITS_COUNTER'(BITS);
  localparam logic [BITS_COUNTER-1:0] LAST_L =
    BITS_COUNTER'(BITS_LONG);
  localparam logic [BITS_COUNTER-1:0] CRC_S_HI =
    BITS_COUNTER'(BITS - 8);
  localparam logic [BITS_COUNTER-1:0] CRC_L_LO =
    BITS_COUNTER'(9);
  localparam logic [BITS_COUNTER-1:0] CRC_L_HI =
    BITS_COUNTER'(BITS_LONG - 8);
  localparam logic [BITS_COUNTER-1:0] TX_BIT =
    BITS_COUNTER'(2);
  localparam logic [TIMEOUT_COUNTER-1:0] WAIT_LAST =
    TIMEOUT_COUNTER'(TIMEOUT - 1);

  sd_state_e state;
  sd_state_e next_state;

  logic [BITS_COUNTER-1:0]    bit_cnt;
  logic [BITS_COUNTER-1:0]    nbit;
  logic [BITS_COUNTER-1:0]    last_bit;
  logic [TIMEOUT_COUNTER-1:0] wait_cnt;
  logic                       long_q;
  logic                       chk_q;
  logic [6:0]                 crc;

  logic arm;
  logic start_hit;
  logic to_hit;
  logic wait_inc;
  logic shift_en;
  logic last_hit;
  logic crc_en;

  // nbit is the 1-based index of the bit sampled this cycle
  assign nbit     = bit_cnt + 1'b1;
  assign last_bit = long_q ? LAST_L : LAST_S;

  sd_crc7 u_crc7 (
    .clk    (clk),
    .reset  (reset),
    .clear  (arm),
    .enable (crc_en),
    .din    (in),
    .crc    (crc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (enable) next_state = WAIT_START;
      end
      WAIT_START: begin
        if (!enable) next_state = IDLE;
        else if (start_hit) next_state = RECEIVE;
        else if (to_hit) next_state = DONE;
      end
      RECEIVE: begin
        if (!enable) next_state = IDLE;
        else if (last_hit) next_state = DONE;
      end
      DONE: begin
        if (!enable) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Start bit beats timeout; abort beats everything
  always_comb begin
    arm       = 1'b0;
    start_hit = 1'b0;
    to_hit    = 1'b0;
    wait_inc  = 1'b0;
    shift_en  = 1'b0;
    last_hit  = 1'b0;
    crc_en    = 1'b0;
    unique case (state)
      IDLE: begin
        arm = enable;
      end
      WAIT_START: begin
        if (enable) begin
          if (!in) begin
            start_hit = 1'b1;
            crc_en    = !long_q;
          end else begin
            wait_inc = 1'b1;
            to_hit   = (wait_cnt == WAIT_LAST);
          end
        end
      end
      RECEIVE: begin
        if (enable) begin
          shift_en = 1'b1;
          last_hit = (nbit == last_bit);
          crc_en   = long_q
            ? (nbit >= CRC_L_LO && nbit <= CRC_L_HI)
            : (nbit <= CRC_S_HI);
        end
      end
      DONE: begin
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out       <= '0;
      done      <= 1'b0;
      crc_err   <= 1'b0;
      frame_err <= 1'b0;
      timeout   <= 1'b0;
      bit_cnt   <= '0;
      wait_cnt  <= '0;
      long_q    <= 1'b0;
      chk_q     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (arm) begin
        out       <= '0;
        crc_err   <= 1'b0;
        frame_err <= 1'b0;
        timeout   <= 1'b0;
        bit_cnt   <= '0;
        wait_cnt  <= '0;
        long_q    <= long_resp;
        chk_q     <= check_crc;
      end
      if (start_hit) begin
        bit_cnt <= BITS_COUNTER'(1);
        out     <= {out[BITS_LONG-2:0], 1'b0};
      end
      if (wait_inc && wait_cnt != '1) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (to_hit) begin
        timeout <= 1'b1;
        done    <= 1'b1;
      end
      if (shift_en) begin
        out <= {out[BITS_LONG-2:0], in};
        if (bit_cnt != '1) bit_cnt <= nbit;
        if (nbit == TX_BIT && in) frame_err <= 1'b1;
        // out[6:0] holds the received CRC just before the end bit
        if (last_hit) begin
          done <= 1'b1;
          if (!in) frame_err <= 1'b1;
          if (chk_q && crc != out[6:0]) crc_err <= 1'b1;
        end
      end
    end
  end

endmodule
